// File: rtl/hp_fifo_ctrl.sv
// Host-to-parasite buffered data register: DEPTH-entry circular store with
// fill/drain sequencing, side flags, parasite NMI request and sticky errors.
module hp_fifo_ctrl #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             h_phi2,
    input  logic             h_rst_b,
    input  logic             h_selectData,
    input  logic             h_we_b,
    input  logic [7:0]       h_data,
    input  logic             p_selectData,
    input  logic             p_rdnw,
    input  logic             mode_two,
    input  logic             nmi_en,
    input  logic             flush,
    input  logic             err_clr,
    output logic [7:0]       p_data,
    output logic             p_data_available,
    output logic             h_full,
    output logic             p_nmi,
    output logic             overrun,
    output logic             underrun,
    output logic [PTR_W:0]   count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [1:0]       state_q,    state_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W:0]   count_q,    count_d;
    logic [PTR_W:0]   active_n_q, active_n_d;
    logic             overrun_q,  overrun_d;
    logic             underrun_q, underrun_d;
    logic             h_full_q;
    logic             p_avail_q;
    logic             p_nmi_q;
    logic [7:0]       mem_q [DEPTH];

    logic             hw_s;
    logic             pr_s;
    logic             mem_we_s;
    logic             ovr_set_s;
    logic             und_set_s;
    logic             ready_d_s;
    logic [PTR_W:0]   act_s;

    assign hw_s = h_selectData & ~h_we_b;
    assign pr_s = p_selectData & p_rdnw;

    // Next-state logic: transfer sequencing, pointer/count update, error events
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_we_s   = 1'b0;
        ovr_set_s  = 1'b0;
        und_set_s  = 1'b0;
        // Transfer size follows mode_two only while idle; frozen for the rest of a transfer
        if (state_q == ST_IDLE) begin
            act_s = mode_two ? CNT_FULL : CNT_ONE;
        end else begin
            act_s = active_n_q;
        end
        active_n_d = act_s;

        if (flush) begin
            state_d  = ST_IDLE;
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (hw_s) begin
                        mem_we_s = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        count_d  = count_q + CNT_ONE;
                        state_d  = ((count_q + CNT_ONE) == act_s) ? ST_READY : ST_FILL;
                    end else begin
                        state_d = state_q;
                    end
                    if (pr_s) begin
                        und_set_s = 1'b1;
                    end else begin
                        und_set_s = 1'b0;
                    end
                end
                ST_READY, ST_DRAIN: begin
                    if (hw_s) begin
                        ovr_set_s = 1'b1;
                    end else begin
                        ovr_set_s = 1'b0;
                    end
                    if (pr_s) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        count_d  = count_q - CNT_ONE;
                        state_d  = (count_q == CNT_ONE) ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A same-cycle error event takes priority over err_clr
        overrun_d  = (overrun_q  & ~err_clr) | ovr_set_s;
        underrun_d = (underrun_q & ~err_clr) | und_set_s;
        ready_d_s  = (state_d == ST_READY) || (state_d == ST_DRAIN);
    end

    // Control state, pointers, counters, sticky errors and registered flags
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            active_n_q <= CNT_ONE;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            h_full_q   <= 1'b0;
            p_avail_q  <= 1'b0;
            p_nmi_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            active_n_q <= active_n_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            h_full_q   <= ready_d_s;
            p_avail_q  <= ready_d_s;
            p_nmi_q    <= nmi_en & ready_d_s;
        end
    end

    // Buffer storage; survives flush so the parasite sees stale data at rd_ptr
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we_s) begin
            mem_q[wr_ptr_q] <= h_data;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign p_data           = mem_q[rd_ptr_q];
    assign p_data_available = p_avail_q;
    assign h_full           = h_full_q;
    assign p_nmi            = p_nmi_q;
    assign overrun          = overrun_q;
    assign underrun         = underrun_q;
    assign count            = count_q;

endmodule

// File: tb/tb_hp_fifo_ctrl.sv
// Scoreboard bench for hp_fifo_ctrl (DEPTH=2): bytes queued on host writes,
// popped and compared against p_data on parasite reads.
module tb_hp_fifo_ctrl;

    logic       h_phi2 = 1'b1;
    logic       h_rst_b;
    logic       h_selectData;
    logic       h_we_b;
    logic [7:0] h_data;
    logic       p_selectData;
    logic       p_rdnw;
    logic       mode_two;
    logic       nmi_en;
    logic       flush;
    logic       err_clr;
    logic [7:0] p_data;
    logic       p_data_available;
    logic       h_full;
    logic       p_nmi;
    logic       overrun;
    logic       underrun;
    logic [1:0] count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb[$];
    bit         m_rdy;
    bit         m_ovr;
    bit         m_und;
    int         m_act;

    hp_fifo_ctrl #(.DEPTH(2), .PTR_W(1)) dut (
        .h_phi2(h_phi2), .h_rst_b(h_rst_b), .h_selectData(h_selectData),
        .h_we_b(h_we_b), .h_data(h_data), .p_selectData(p_selectData),
        .p_rdnw(p_rdnw), .mode_two(mode_two), .nmi_en(nmi_en), .flush(flush),
        .err_clr(err_clr), .p_data(p_data), .p_data_available(p_data_available),
        .h_full(h_full), .p_nmi(p_nmi), .overrun(overrun), .underrun(underrun),
        .count(count)
    );

    always #5 h_phi2 = ~h_phi2;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".h_full"}, 32'(h_full), 32'(m_rdy));
        check_eq({tag, ".avail"}, 32'(p_data_available), 32'(m_rdy));
        check_eq({tag, ".nmi"}, 32'(p_nmi), 32'(nmi_en & m_rdy));
        check_eq({tag, ".count"}, 32'(count), 32'(sb.size()));
        check_eq({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
        check_eq({tag, ".und"}, 32'(underrun), 32'(m_und));
        if (m_rdy) begin
            check_eq({tag, ".p_data"}, 32'(p_data), 32'(sb[0]));
        end
    endtask

    task automatic idle_inputs();
        h_selectData = 1'b0;
        h_we_b       = 1'b1;
        h_data       = 8'h00;
        p_selectData = 1'b0;
        p_rdnw       = 1'b1;
        flush        = 1'b0;
        err_clr      = 1'b0;
    endtask

    // Entered and left just after a rising edge; the DUT acts on the falling edge between.
    task automatic step(input string tag, input bit hw, input bit pr, input logic [7:0] d,
                        input bit fl, input bit ec);
        h_selectData = hw;
        h_we_b       = ~hw;
        h_data       = d;
        p_selectData = pr;
        p_rdnw       = 1'b1;
        flush        = fl;
        err_clr      = ec;
        if (ec) begin
            m_ovr = 1'b0;
            m_und = 1'b0;
        end
        if (fl) begin
            sb.delete();
            m_rdy = 1'b0;
        end else if (!m_rdy) begin
            if (sb.size() == 0) m_act = mode_two ? 2 : 1;
            if (pr) m_und = 1'b1;
            if (hw) begin
                sb.push_back(d);
                if (sb.size() == m_act) m_rdy = 1'b1;
            end
        end else begin
            if (hw) m_ovr = 1'b1;
            if (pr) begin
                check_eq({tag, ".rd"}, 32'(p_data), 32'(sb[0]));
                void'(sb.pop_front());
                if (sb.size() == 0) m_rdy = 1'b0;
            end
        end
        @(negedge h_phi2);
        @(posedge h_phi2);
        #1;
        idle_inputs();
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        h_rst_b = 1'b0;
        #1;
        sb.delete();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        m_und = 1'b0;
        check_state(tag);
        check_eq({tag, ".p_data0"}, 32'(p_data), 32'h0);
        @(posedge h_phi2);
        #1;
        h_rst_b = 1'b1;
    endtask

    initial begin
        h_rst_b  = 1'b0;
        mode_two = 1'b0;
        nmi_en   = 1'b0;
        idle_inputs();
        repeat (2) @(posedge h_phi2);
        #1;
        do_reset("rst");

        // one-byte mode
        step("t1w", 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        step("t1r", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // two-byte fill then drain
        mode_two = 1'b1;
        step("t2w1", 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        step("t2w2", 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        step("t2r1", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("t2r2", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // overrun in READY, then simultaneous write+read in READY
        step("t3w1", 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        step("t3w2", 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        step("t3ov", 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        step("t3clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step("t3wr", 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        step("t3dr", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        step("t3clr2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // underrun in IDLE and FILL; err_clr loses to a same-cycle read
        step("t4ri", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("t4clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step("t4w", 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        step("t4rf", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("t4w2", 1'b1, 1'b0, 8'h88, 1'b0, 1'b0);
        step("t4r1", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("t4r2", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("t4clr2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step("t4rc", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        step("t4clr3", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // NMI
        mode_two = 1'b0;
        nmi_en   = 1'b1;
        step("t5w", 1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        step("t5r", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        nmi_en = 1'b0;
        step("t5w0", 1'b1, 1'b0, 8'h9A, 1'b0, 1'b0);
        step("t5r0", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // mode change mid-FILL is deferred until IDLE
        mode_two = 1'b1;
        step("t6w1", 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        mode_two = 1'b0;
        step("t6hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step("t6w2", 1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
        step("t6r1", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("t6r2", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // flush in DRAIN beats a same-cycle read; rd_ptr back to slot 0
        do_reset("rst2");
        mode_two = 1'b1;
        step("t6fw1", 1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
        step("t6fw2", 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        step("t6fr", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("t6fl", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        check_eq("t6fl.stale", 32'(p_data), 32'h44);

        // asynchronous reset mid-FILL
        step("t6rw", 1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
        do_reset("rst3");
        step("t6post", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
